// File: rtl/cells_commit.sv
// rtl/cells_commit.sv - streams next-state RAM into VRAM one cell per clock, clears RAM, overlays brush square
module cells_commit #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 2,
    parameter int BRUSH_RADIUS   = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               start_i,
    input  logic                               brush_en_i,
    input  logic [$clog2(ACTIVE_COLUMNS)-1:0]  brush_x_i,
    input  logic [$clog2(ACTIVE_ROWS)-1:0]     brush_y_i,
    input  logic [DATA_WIDTH-1:0]              brush_type_i,
    input  logic [DATA_WIDTH-1:0]              ram_rd_data,
    output logic [ADDR_WIDTH-1:0]              ram_rd_address_o,
    output logic [ADDR_WIDTH-1:0]              ram_wr_address_o,
    output logic [DATA_WIDTH-1:0]              ram_wr_data_o,
    output logic                               ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]              vram_wr_address_o,
    output logic [DATA_WIDTH-1:0]              vram_wr_data_o,
    output logic                               vram_wr_en_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int CW = $clog2(ACTIVE_COLUMNS);
    localparam int RW = $clog2(ACTIVE_ROWS);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ACTIVE_COLUMNS * ACTIVE_ROWS - 1);
    localparam logic [CW-1:0]         COL_LAST  = CW'(ACTIVE_COLUMNS - 1);
    localparam logic [CW:0]           R_COL     = (CW + 1)'(BRUSH_RADIUS);
    localparam logic [RW:0]           R_ROW     = (RW + 1)'(BRUSH_RADIUS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic                    br_en_q, br_en_d;
    logic [CW-1:0]           br_x_q, br_x_d;
    logic [RW-1:0]           br_y_q, br_y_d;
    logic [DATA_WIDTH-1:0]   br_type_q, br_type_d;

    // One extra bit keeps both sides of each comparison free of wrap, so edge squares clip naturally.
    logic [CW:0] col_ext, bx_ext;
    logic [RW:0] row_ext, by_ext;
    logic        in_brush;

    assign col_ext  = {1'b0, col_q};
    assign bx_ext   = {1'b0, br_x_q};
    assign row_ext  = {1'b0, row_q};
    assign by_ext   = {1'b0, br_y_q};
    assign in_brush = br_en_q
                    && (col_ext + R_COL >= bx_ext) && (col_ext <= bx_ext + R_COL)
                    && (row_ext + R_ROW >= by_ext) && (row_ext <= by_ext + R_ROW);

    logic [DATA_WIDTH-1:0] cell_val;

    always_comb begin
        cell_val = ram_rd_data;
        if (in_brush) begin
            if (br_type_q == '0) begin
                cell_val = '0;
            end else if (ram_rd_data == '0) begin
                cell_val = br_type_q;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        col_d             = col_q;
        row_d             = row_q;
        br_en_d           = br_en_q;
        br_x_d            = br_x_q;
        br_y_d            = br_y_q;
        br_type_d         = br_type_q;
        ram_rd_address_o  = '0;
        ram_wr_address_o  = '0;
        ram_wr_data_o     = '0;
        ram_wr_en_o       = 1'b0;
        vram_wr_address_o = '0;
        vram_wr_data_o    = '0;
        vram_wr_en_o      = 1'b0;
        busy_o            = 1'b0;
        done_o            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    br_en_d   = brush_en_i;
                    br_x_d    = brush_x_i;
                    br_y_d    = brush_y_i;
                    br_type_d = brush_type_i;
                    addr_d    = '0;
                    col_d     = '0;
                    row_d     = '0;
                    state_d   = S_COPY;
                end
            end

            S_COPY: begin
                busy_o            = 1'b1;
                vram_wr_en_o      = 1'b1;
                vram_wr_address_o = addr_q;
                vram_wr_data_o    = cell_val;
                ram_wr_en_o       = 1'b1;
                ram_wr_address_o  = addr_q;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_DONE;
                end else begin
                    ram_rd_address_o = addr_q + 1'b1;
                    addr_d           = addr_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            br_en_q   <= 1'b0;
            br_x_q    <= '0;
            br_y_q    <= '0;
            br_type_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            col_q     <= col_d;
            row_q     <= row_d;
            br_en_q   <= br_en_d;
            br_x_q    <= br_x_d;
            br_y_q    <= br_y_d;
            br_type_q <= br_type_d;
        end
    end

endmodule

// File: tb/tb_cells_commit.sv
// tb/tb_cells_commit.sv - self-checking bench for cells_commit on an 8x4 frame
module tb_cells_commit;

    localparam int COLS = 8;
    localparam int ROWS = 4;
    localparam int R    = 1;
    localparam int N    = COLS * ROWS;
    localparam int AW   = 5;
    localparam int DW   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          brush_en = 1'b0;
    logic [2:0]    bx = '0;
    logic [1:0]    by = '0;
    logic [DW-1:0] btype = '0;
    logic [DW-1:0] ram_rd_data = '0;
    logic [AW-1:0] ram_rd_address, ram_wr_address, vram_wr_address;
    logic [DW-1:0] ram_wr_data, vram_wr_data;
    logic          ram_wr_en, vram_wr_en, busy, done;

    always #5 clk = ~clk;

    cells_commit #(
        .ACTIVE_COLUMNS(COLS),
        .ACTIVE_ROWS   (ROWS),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BRUSH_RADIUS  (R)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .start_i          (start),
        .brush_en_i       (brush_en),
        .brush_x_i        (bx),
        .brush_y_i        (by),
        .brush_type_i     (btype),
        .ram_rd_data      (ram_rd_data),
        .ram_rd_address_o (ram_rd_address),
        .ram_wr_address_o (ram_wr_address),
        .ram_wr_data_o    (ram_wr_data),
        .ram_wr_en_o      (ram_wr_en),
        .vram_wr_address_o(vram_wr_address),
        .vram_wr_data_o   (vram_wr_data),
        .vram_wr_en_o     (vram_wr_en),
        .busy_o           (busy),
        .done_o           (done)
    );

    logic [DW-1:0] ram    [N];
    logic [DW-1:0] vram   [N];
    logic [DW-1:0] preset [N];
    logic [DW-1:0] pre_m  [N];
    logic          load = 1'b0;

    // Dual-ported RAM with registered read, plus VRAM; load reinitialises both.
    always @(posedge clk) begin
        ram_rd_data <= ram[ram_rd_address];
        if (load) begin
            ram <= preset;
            for (int i = 0; i < N; i++) vram[i] <= 2'b11;
        end else begin
            if (ram_wr_en)  ram[ram_wr_address]   <= ram_wr_data;
            if (vram_wr_en) vram[vram_wr_address] <= vram_wr_data;
        end
    end

    int cyc = 0;
    int last_done = -1;
    int prev_done = -1;
    int wr_total = 0;
    int bad_wr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) begin
            prev_done <= last_done;
            last_done <= cyc;
        end
        if (vram_wr_en) wr_total <= wr_total + 1;
        if ((vram_wr_en !== ram_wr_en) || (busy !== vram_wr_en) ||
            (vram_wr_en && ((vram_wr_address !== ram_wr_address) || (ram_wr_data !== 2'b00))))
            bad_wr <= bad_wr + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected cell from the brush rules, using signed distances on row/column.
    function automatic int model_cell(int k, int pre, bit en, int x, int y, int t);
        int col = k % COLS;
        int row = k / COLS;
        bit in_sq = en && (col >= x - R) && (col <= x + R) && (row >= y - R) && (row <= y + R);
        if (!in_sq) return pre;
        if (t == 0) return 0;
        return (pre == 0) ? t : pre;
    endfunction

    function automatic int outs_or();
        return int'(ram_rd_address) | int'(ram_wr_address) | int'(ram_wr_data) | int'(ram_wr_en)
             | int'(vram_wr_address) | int'(vram_wr_data) | int'(vram_wr_en) | int'(busy) | int'(done);
    endfunction

    task automatic check_frame(input string tag, input bit en, input int x, input int y, input int t);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_vram%0d", tag, k), int'(vram[k]), model_cell(k, int'(pre_m[k]), en, x, y, t));
            check($sformatf("%s_ram%0d", tag, k), int'(ram[k]), 0);
        end
    endtask

    task automatic run_pass(input string tag, input bit do_load, input bit en, input int x,
                            input int y, input int t, input bit scramble);
        int c0, w0;
        if (do_load) begin
            @(posedge clk); #1 load = 1'b1;
            @(posedge clk); #1 load = 1'b0;
            pre_m = preset;
        end
        brush_en = en; bx = 3'(x); by = 2'(y); btype = 2'(t);
        start = 1'b1;
        c0 = cyc;
        w0 = wr_total;
        check({tag, "_idle_busy"}, int'(busy), 0);
        check({tag, "_idle_rdaddr"}, int'(ram_rd_address), 0);
        @(posedge clk); #1 start = 1'b0;
        if (scramble) begin
            brush_en = 1'($urandom); bx = 3'($urandom); by = 2'($urandom); btype = 2'($urandom);
        end
        check({tag, "_c1_busy"}, int'(busy), 1);
        check({tag, "_c1_wraddr"}, int'(vram_wr_address), 0);
        check({tag, "_c1_rdaddr"}, int'(ram_rd_address), 1);
        repeat (N + 1) @(posedge clk);
        #1;
        check({tag, "_done_cycle"}, last_done - c0, N + 1);
        check({tag, "_wr_count"}, wr_total - w0, N);
        check({tag, "_idle_after"}, int'(busy) | int'(done), 0);
        check({tag, "_wr_port"}, bad_wr, 0);
        check_frame(tag, en, x, y, t);
    endtask

    initial begin
        int c0, nz, ex_x, ex_y;
        #1;
        check("reset_outputs", outs_or(), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_reset_outputs", outs_or(), 0);

        for (int k = 0; k < N; k++) preset[k] = 2'(k % 3);
        run_pass("plain", 1'b1, 1'b0, 0, 0, 1, 1'b0);
        for (int k = 0; k < N; k++) preset[k] = 2'b00;
        run_pass("sand", 1'b1, 1'b1, 3, 1, 1, 1'b0);
        run_pass("corner", 1'b1, 1'b1, 0, 0, 1, 1'b0);
        nz = 0;
        for (int k = 0; k < N; k++) if (vram[k] != 2'b00) nz++;
        check("corner_count", nz, 4);
        check("corner_addr9", int'(vram[9]), 1);

        for (int k = 0; k < N; k++) preset[k] = 2'b10;
        run_pass("eraser", 1'b1, 1'b1, 7, 3, 0, 1'b1);
        check("eraser_addr31", int'(vram[31]), 0);
        check("eraser_addr21", int'(vram[21]), 2);

        for (int k = 0; k < N; k++) preset[k] = 2'b00;
        preset[11] = 2'b10;
        run_pass("noover", 1'b1, 1'b1, 3, 1, 1, 1'b0);
        check("noover_addr11", int'(vram[11]), 2);

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < N; k++) preset[k] = 2'($urandom_range(0, 2));
            run_pass($sformatf("rnd%0d", p), 1'b1, 1'($urandom), $urandom_range(0, COLS - 1),
                     $urandom_range(0, ROWS - 1), $urandom_range(0, 2), 1'b1);
        end

        // start held high: passes must run back to back with one IDLE cycle between.
        for (int k = 0; k < N; k++) preset[k] = 2'(k % 3);
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        brush_en = 1'b0;
        start = 1'b1;
        c0 = cyc;
        repeat (N + 2) @(posedge clk);
        #1;
        check("b2b_gap_busy", int'(busy), 0);
        check("b2b_first_done", last_done - c0, N + 1);
        repeat (N + 2) @(posedge clk);
        #1;
        check("b2b_spacing", last_done - prev_done, N + 2);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset ten cycles into a pass, then restart without reloading memory.
        for (int k = 0; k < N; k++) preset[k] = 2'($urandom_range(0, 2));
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        ex_x = $urandom_range(0, COLS - 1);
        ex_y = $urandom_range(0, ROWS - 1);
        brush_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midreset_outputs", outs_or(), 0);
        @(posedge clk); #1 rst = 1'b0;
        check("midreset_idle", outs_or(), 0);
        pre_m = preset;
        for (int k = 0; k < 9; k++) pre_m[k] = 2'b00;
        run_pass("restart", 1'b0, 1'b1, ex_x, ex_y, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cells_commit.md
# cells_commit

Frame-commit engine for the falling-sand pipeline. It runs after `cells_next_state` asserts `done_o`. It streams the next-state RAM back into VRAM one cell per clock and clears each RAM cell as it goes, so the RAM is empty for the next generation. On the way through it overlays the user brush square. It is the write-back counterpart of `cells_next_state`: that block reads VRAM and writes RAM; this block reads RAM and writes VRAM.

## Interface
- `ACTIVE_COLUMNS`, 640, frame width in cells
- `ACTIVE_ROWS`, 480, frame height in cells
- `ADDR_WIDTH`, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width
- `DATA_WIDTH`, 2, cell state width (00 empty, 01 sand, 10 water)
- `BRUSH_RADIUS`, 2, brush half-width; the brush square is (2R+1)x(2R+1) cells
- `clk_i`  in  1  single clock
- `reset_i`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  begin a commit pass; sampled only in IDLE
- `brush_en_i`  in  1  apply the brush during this pass
- `brush_x_i`  in  $clog2(ACTIVE_COLUMNS)  brush centre column
- `brush_y_i`  in  $clog2(ACTIVE_ROWS)  brush centre row
- `brush_type_i`  in  DATA_WIDTH  material; 00 means eraser
- `ram_rd_data`  in  DATA_WIDTH  RAM read data, valid one cycle after the address
- `ram_rd_address_o`  out  ADDR_WIDTH  RAM read address
- `ram_wr_address_o`, `ram_wr_data_o`, `ram_wr_en_o`  out  ADDR_WIDTH / DATA_WIDTH / 1  RAM clear port
- `vram_wr_address_o`, `vram_wr_data_o`, `vram_wr_en_o`  out  ADDR_WIDTH / DATA_WIDTH / 1  VRAM write port
- `busy_o`  out  1  high while a pass is in progress (COPY)
- `done_o`  out  1  one-cycle pulse when a pass completes

## Operation
- **States:** IDLE, COPY, DONE. Reset puts the block in IDLE with `addr_reg`=0, `col_reg`=0, `row_reg`=0 and all brush latches at 0.
- **IDLE:**
  - On `start_i`, latch the four `brush_*` inputs, clear `addr_reg`, `col_reg` and `row_reg`, drive `ram_rd_address_o`=0 combinationally, and go to COPY.
  - Without `start_i`, drive every output to 0.
- **COPY, every cycle:** `ram_rd_data` holds RAM[`addr_reg`].
  - Cell value: d = `ram_rd_data`.
  - If the brush is enabled and the cell is inside the brush square:
    - eraser (type 00): d = 0;
    - any other type: d = latched type, but only when `ram_rd_data`==0. Occupied cells are never overwritten.
  - Write VRAM[`addr_reg`] = d.
  - Write RAM[`addr_reg`] = 0.
  - Drive `ram_rd_address_o` = `addr_reg`+1.
  - Advance `addr_reg`. `col_reg` wraps at ACTIVE_COLUMNS-1 to 0 and increments `row_reg`.
- **Inside test:** `col_reg`+R >= bx AND `col_reg` <= bx+R AND `row_reg`+R >= by AND `row_reg` <= by+R.
  - Compute with one extra bit so that no underflow or overflow occurs; no subtraction is used.
  - Brush squares that touch the frame edge are clipped naturally by this test.
- **Last cell:** when `addr_reg` == ACTIVE_COLUMNS*ACTIVE_ROWS-1, perform that cell's writes, drive `ram_rd_address_o`=0, and go to DONE.
- **DONE:** assert `done_o` for one cycle, drive no writes, return to IDLE.
- **No addressing arithmetic:** addresses are never formed by multiplying or dividing row and column; the counters run in lock-step with `addr_reg`.
- **Ignored inputs:**
  - `start_i` in COPY or DONE.
  - Changes to `brush_*` mid-pass; the latched values apply for the whole pass.
- **Reset mid-pass:** immediate return to IDLE with outputs 0. VRAM and RAM keep whatever was partially written. Upper-level control restarts the generation.

## Timing
- **Reset values:** all outputs 0.
- **Pass timeline** (N = ACTIVE_COLUMNS*ACTIVE_ROWS; start sampled at cycle 0):
  - cycle 0: RAM read address 0 presented.
  - cycles 1..N: COPY; address k is written at cycle k+1.
  - cycle N+1: `done_o` pulses.
  - cycle N+2: IDLE; a new `start_i` is accepted here.
- **Throughput:** one cell per clock, no bubbles. Total pass length is N+2 cycles from start to IDLE.
- **Write enables:** `vram_wr_en_o` and `ram_wr_en_o` are both high on exactly the N COPY cycles. Their addresses are equal.
- **`busy_o`:** equals (state==COPY).
- **Output timing:** all outputs are combinational from state, counters and `ram_rd_data`. The RAM must have a one-cycle registered read and be dual-ported: read at k+1 and write at k happen in the same cycle.

## Test plan
Use ACTIVE_COLUMNS=8, ACTIVE_ROWS=4, R=1 (N=32).
- **Plain copy:** RAM preset to address mod 3, brush off, pulse start -> VRAM[k]=k mod 3 for all k; RAM all 0 afterwards; `done_o` high exactly at cycle 33; exactly 32 write cycles.
- **Brush sand on empty frame:** RAM all 0, brush (x=3, y=1, type 01) -> VRAM=01 at rows 0-2, columns 2-4 (9 cells); all other cells 0.
- **Corner clip and eraser:**
  - brush (x=0, y=0, type 01) -> exactly 4 cells set: addresses 0, 1, 8, 9.
  - RAM all 10, eraser at (7, 3) -> VRAM addresses 22, 23, 30, 31 = 0; all others 10.
- **No overwrite:** RAM[11]=10, brush (3, 1, type 01) -> VRAM[11]=10; the other 8 cells in the square = 01.
- **Start ignored mid-pass, then reset mid-pass:**
  - `start_i` held high throughout -> passes run back-to-back with a one-cycle IDLE gap; `done_o` pulses are 34 cycles apart.
  - `reset_i` at cycle 10 -> all outputs 0 in the same cycle; the next `start_i` restarts from address 0.
